// File: rtl/expr_share_sched.sv
// Multi-cycle scheduler for the six-result common-subexpression set, using one shared add/sub unit and one shared multiplier.
// Optional job counter port job_cnt is enabled by defining EXPR_SCHED_JOBCNT_EN.
module expr_share_sched #(
    parameter int W = 32
`ifdef EXPR_SCHED_JOBCNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] e,
    input  logic [W-1:0] f,
    input  logic [W-1:0] g,
    input  logic [W-1:0] h,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r1,
    output logic [W-1:0] r2,
    output logic [W-1:0] r3,
    output logic [W-1:0] r4,
    output logic [W-1:0] r5,
    output logic [W-1:0] r6,
    output logic         busy
`ifdef EXPR_SCHED_JOBCNT_EN
    ,
    output logic [CNT_W-1:0] job_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and data stable until then, and ready never waits on valid.
    typedef enum logic [3:0] {
        IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, OUT
    } state_t;

    state_t state;

    logic [W-1:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
    logic [W-1:0] ab, cd, ef, t0, t1, t2, t3, t4;

    logic [W-1:0] add_x, add_y, add_res;
    logic         add_sub;
    logic [W-1:0] mul_x, mul_y, mul_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // Operand steering for the shared units; idle steps feed zeros.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        mul_x   = '0;
        mul_y   = '0;
        case (state)
            S1:  begin add_x = op_a; add_y = op_b; mul_x = op_c; mul_y = op_d; end
            S2:  begin add_x = op_e; add_y = op_f; add_sub = 1'b1; end
            S3:  begin add_x = ab;   add_y = cd;   end
            S4:  begin add_x = cd;   add_y = ef;   end
            S5:  begin add_x = ab;   add_y = op_g; end
            S6:  begin add_x = t0;   add_y = op_h; end
            S7:  begin add_x = cd;   add_y = op_e; end
            S8:  begin add_x = ab;   add_y = op_c; mul_x = t1; mul_y = ab; end
            S9:  begin add_x = op_f; add_y = ab;   mul_x = t2; mul_y = ef; end
            S10: begin add_x = cd;   add_y = op_b; end
            S11: begin add_x = t4;   add_y = t3;   add_sub = 1'b1; end
            default: ;
        endcase
    end

    assign add_res = add_sub ? (add_x - add_y) : (add_x + add_y);
    assign mul_res = mul_x * mul_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a <= '0; op_b <= '0; op_c <= '0; op_d <= '0;
            op_e <= '0; op_f <= '0; op_g <= '0; op_h <= '0;
            ab <= '0; cd <= '0; ef <= '0;
            t0 <= '0; t1 <= '0; t2 <= '0; t3 <= '0; t4 <= '0;
            r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0; r5 <= '0; r6 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= a; op_b <= b; op_c <= c; op_d <= d;
                        op_e <= e; op_f <= f; op_g <= g; op_h <= h;
                        state <= S1;
                    end
                end
                S1:  begin ab <= add_res; cd <= mul_res; state <= S2; end
                S2:  begin ef <= add_res; state <= S3;  end
                S3:  begin r1 <= add_res; state <= S4;  end
                S4:  begin r2 <= add_res; state <= S5;  end
                S5:  begin t0 <= add_res; state <= S6;  end
                S6:  begin r3 <= add_res; state <= S7;  end
                S7:  begin t1 <= add_res; state <= S8;  end
                S8:  begin r4 <= mul_res; t2 <= add_res; state <= S9; end
                S9:  begin r6 <= mul_res; t3 <= add_res; state <= S10; end
                S10: begin t4 <= add_res; state <= S11; end
                S11: begin r5 <= add_res; state <= OUT; end
                OUT: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXPR_SCHED_JOBCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cnt <= '0;
        end else if (out_valid && out_ready) begin
            job_cnt <= job_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_expr_share_sched.sv
// Self-checking bench for expr_share_sched: scoreboard queue filled at operand
// acceptance, drained by a monitor on each output handshake.
module tb_expr_share_sched;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0, h = '0;
    logic [W-1:0] r1, r2, r3, r4, r5, r6;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [6*W-1:0] exp_q[$];
    logic [6*W-1:0] mon_e;

`ifdef EXPR_SCHED_JOBCNT_EN
    logic [1:0] job_cnt;
    logic [1:0] jc_exp = '0;
    logic       jc_pending = 1'b0;

    expr_share_sched #(.W(W), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6),
        .busy(busy), .job_cnt(job_cnt)
    );
`else
    expr_share_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6),
        .busy(busy)
    );
`endif

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, expv);
        end
    endtask

    function automatic logic [6*W-1:0] model(input logic [W-1:0] va, vb, vc, vd, ve, vf, vg, vh);
        logic [W-1:0] xab, xcd, xef, x1, x2, x3, x4, x5, x6, tmp;
        xab = va + vb;
        xcd = vc * vd;
        xef = ve - vf;
        x1  = xab + xcd;
        x2  = xcd + xef;
        x3  = xab + vg + vh;
        tmp = xcd + ve;
        x4  = tmp * xab;
        x5  = (xcd + vb) - (vf + xab);
        tmp = xab + vc;
        x6  = tmp * xef;
        return {x1, x2, x3, x4, x5, x6};
    endfunction

    // driver: present operands, wait (bounded) for acceptance, push expected
    task automatic send_job(input logic [W-1:0] va, vb, vc, vd, ve, vf, vg, vh);
        bit taken;
        taken = 1'b0;
        @(posedge clk); #1;
        a = va; b = vb; c = vc; d = vd; e = ve; f = vf; g = vg; h = vh;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            check("accept_timeout", 1'b0, 1'b1);
        end else begin
            acc_cyc = cyc + 1;
            exp_q.push_back(model(va, vb, vc, vd, ve, vf, vg, vh));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        e = $urandom; f = $urandom; g = $urandom; h = $urandom;
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("out_timeout", 1'b0, 1'b1);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
`ifdef EXPR_SCHED_JOBCNT_EN
        if (jc_pending) begin
            check("job_cnt", W'(job_cnt), W'(jc_exp));
            jc_pending = 1'b0;
        end
`endif
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("r1", r1, mon_e[6*W-1 -: W]);
                check("r2", r2, mon_e[5*W-1 -: W]);
                check("r3", r3, mon_e[4*W-1 -: W]);
                check("r4", r4, mon_e[3*W-1 -: W]);
                check("r5", r5, mon_e[2*W-1 -: W]);
                check("r6", r6, mon_e[W-1 -: W]);
`ifdef EXPR_SCHED_JOBCNT_EN
                jc_exp = jc_exp + 1'b1;
                jc_pending = 1'b1;
`endif
            end
        end
    end

    int a1, a2;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_r1", r1, '0);
        check("rst_r6", r6, '0);
`ifdef EXPR_SCHED_JOBCNT_EN
        check("rst_job_cnt", W'(job_cnt), '0);
`endif
        rst_n = 1'b1;

        // basic job and latency
        out_ready = 1'b1;
        send_job(1, 2, 3, 4, 10, 5, 7, 8);
        a1 = acc_cyc;
        wait_out();
        check("t1_latency", W'(cyc - a1), 11);

        // wrap / truncation
        send_job(32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 0, 1, 0, 0);
        wait_out();

        // backpressure: results held for 20 cycles
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_job(1, 2, 3, 4, 10, 5, 7, 8);
        wait_out();
        for (int k = 0; k < 20; k++) begin
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            if (exp_q.size() > 0) begin
                mon_e = exp_q[0];
                check("stall_r1", r1, mon_e[6*W-1 -: W]);
                check("stall_r4", r4, mon_e[3*W-1 -: W]);
                check("stall_r6", r6, mon_e[W-1 -: W]);
            end else begin
                check("stall_queue", 1'b0, 1'b1);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_in_ready", in_ready, 1'b1);
        check("post_hs_busy", busy, 1'b0);
        check("post_hs_out_valid", out_valid, 1'b0);

        // async reset during S5 aborts the job
        send_job(1, 2, 3, 4, 10, 5, 7, 8);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_r1", r1, '0);
        check("abort_r2", r2, '0);
        exp_q.delete();
`ifdef EXPR_SCHED_JOBCNT_EN
        jc_exp = '0;
        jc_pending = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send_job(1, 2, 3, 4, 10, 5, 7, 8);
        wait_out();

        // back-to-back: second job held valid while the first is busy
        send_job(1, 2, 3, 4, 10, 5, 7, 8);
        a1 = acc_cyc;
        send_job(32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 0, 1, 0, 0);
        a2 = acc_cyc;
        check("b2b_gap", W'(a2 - a1), 13);

        // random operand sets
        for (int j = 0; j < 4; j++) begin
            send_job($urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // drain
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("drain", W'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
